text_console_writer: RTL
========================

# text_console_writer

Character-stream front end for the text display pipeline. It accepts ASCII characters over a valid/ready handshake, tracks a cursor over the GRID_ROW x GRID_COL character grid, and handles control codes (CR, LF, BS, FF), line wrap and row clearing. For each displayed cell it issues one write on the display buffer write port (bufferWe/bufferAddr/bufferData), which it drives directly in place of the CPU bus.

## Interface
Parameters:
- GRID_ROW, 5, character rows
- GRID_COL, 10, character columns
- ASCII_WIDTH, 8, character code width
- DEF_FG, 4'hF, foreground CLUT index after reset
- DEF_BG, 4'h0, background CLUT index after reset

Ports (one clock; reset is synchronous and active-high):
- clk_pix  in  1  pixel clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- char_valid  in  1  char_data is valid
- char_ready  out  1  block accepts a character this cycle
- char_data  in  ASCII_WIDTH  character code
- attr_we  in  1  load the colour attribute register
- attr_data  in  8  [7:4] background index, [3:0] foreground index
- cursor_x  out  $clog2(GRID_COL)  current column
- cursor_y  out  $clog2(GRID_ROW)  current row
- bufferWe  out  1  buffer write strobe, one cycle per cell
- bufferAddr  out  32  linear cell index row*GRID_COL+col, zero-extended
- bufferData  out  32  {16'h0, bg[3:0], fg[3:0], ascii[7:0]}

## Operation
- FSM states: CLEAR_ALL, IDLE, WRITE, CLEAR_ROW.
- A character is accepted on any edge where char_valid and char_ready are both high. char_ready is high only in IDLE.
- Blank cell value: 8'h20 with the current fg/bg.
- Printable characters (0x20–0x7E):
  - WRITE issues one write at (cursor_y, cursor_x), then advances the cursor.
  - If cursor_x was GRID_COL-1: cursor_x goes to 0, cursor_y advances, and the FSM enters CLEAR_ROW for the new row.
  - Otherwise the FSM returns to IDLE.
- 0x0A (LF): cursor_x goes to 0, cursor_y advances, FSM enters CLEAR_ROW. No character write.
- 0x0D (CR): cursor_x goes to 0; back to IDLE. No write.
- 0x08 (BS):
  - If cursor_x > 0: cursor_x decrements and WRITE writes a blank at the new position.
  - At cursor_x == 0: nothing happens (no row change).
- 0x0C (FF): CLEAR_ALL; cursor goes to (0,0).
- All other codes: accepted and discarded; back to IDLE with no write.
- Row advance wraps: GRID_ROW-1 goes to 0. There is no scrolling; the wrapped-to row is cleared.
- CLEAR_ROW writes blanks to cells row*GRID_COL .. row*GRID_COL+GRID_COL-1, one per cycle in ascending order, then goes to IDLE.
- CLEAR_ALL writes blanks to cells 0 .. GRID_ROW*GRID_COL-1, one per cycle, then goes to IDLE with the cursor at (0,0).
- Attributes:
  - attr_we loads {bg,fg} in any state.
  - An accepted character is latched with the attribute value held before that edge, so a simultaneous attr_we affects only later characters.
  - A clear in progress uses the attribute value current at each write cycle.
- Width rules:
  - Address arithmetic uses $clog2(GRID_ROW*GRID_COL) bits.
  - bufferAddr upper bits are 0.
  - bufferData[31:16] = 0.

## Timing
- During rst:
  - bufferWe=0, bufferAddr=0, bufferData=0, char_ready=0.
  - cursor=(0,0), fg=DEF_FG, bg=DEF_BG.
  - FSM is in CLEAR_ALL with cell counter 0.
- After rst deasserts: bufferWe is high on the first cycle, with bufferAddr 0, 1, … on consecutive cycles through GRID_ROW*GRID_COL-1. char_ready rises the cycle after the last clear write.
- Character written at acceptance edge T: bufferWe/bufferAddr/bufferData are registered and valid in the cycle after T.
  - char_ready is low in that cycle.
  - The cursor updates and char_ready returns high at the next edge (2 cycles per character when no clear follows).
- A CLEAR_ROW following a wrap or LF adds GRID_COL cycles with char_ready low.
- rst asserted mid-operation (including mid-clear) aborts immediately. Reset values take effect at that edge, and a full CLEAR_ALL restarts from cell 0.
- bufferWe is never high in IDLE.

## Test plan
- Reset release, defaults: 50 consecutive writes, addresses 0–49, data 32'h0000_0F20; char_ready rises after address 49; cursor (0,0).
- Feed "AB" after init: writes addr 0 data 0x0F41, then addr 1 data 0x0F42; cursor (2,0); each character busy for exactly 2 cycles.
- attr_we=8'h1E together with accepting 'C' at cursor (2,0), then send 'D':
  - 'C' written as 0x0F43 at addr 2.
  - 'D' written as 0x1E44 at addr 3.
- Wrap: cursor (9,4), send 'Z':
  - Write addr 49.
  - Then 10 blank writes at addresses 0–9.
  - Cursor (0,0); char_ready low 11 cycles.
- Control codes from cursor (3,1):
  - BS: writes a blank at addr 12; cursor (2,1).
  - CR: no write; cursor (0,1).
  - BS at col 0: no write, cursor unchanged.
  - LF: clears addresses 20–29; cursor (0,2).
  - 0x07: no write.
- FF during a stream, then rst asserted at the 20th clear write: the clear restarts at address 0; fg/bg return to F/0; no further writes after address 49.

Source files
------------

// File: rtl/text_console_writer.sv
// Character-stream front end: accepts ASCII over valid/ready, tracks a cursor
// over the character grid and issues one display-buffer write per touched cell.
module text_console_writer #(
  parameter int         GRID_ROW    = 5,
  parameter int         GRID_COL    = 10,
  parameter int         ASCII_WIDTH = 8,
  parameter logic [3:0] DEF_FG      = 4'hF,
  parameter logic [3:0] DEF_BG      = 4'h0
) (
  input  logic                        clk_pix,
  input  logic                        rst,
  input  logic                        char_valid,
  output logic                        char_ready,
  input  logic [ASCII_WIDTH-1:0]      char_data,
  input  logic                        attr_we,
  input  logic [7:0]                  attr_data,
  output logic [$clog2(GRID_COL)-1:0] cursor_x,
  output logic [$clog2(GRID_ROW)-1:0] cursor_y,
  output logic                        bufferWe,
  output logic [31:0]                 bufferAddr,
  output logic [31:0]                 bufferData
);

  localparam int CELLS = GRID_ROW * GRID_COL;
  localparam int AW    = $clog2(CELLS);
  localparam int XW    = $clog2(GRID_COL);
  localparam int YW    = $clog2(GRID_ROW);
  localparam int CW    = AW + 1;
  localparam logic [7:0] BLANK = 8'h20;

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, WRITE, CLEAR_ROW} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XW-1:0]   curX_q;
  logic [YW-1:0]   curY_q;
  logic [3:0]      fg_q, bg_q;
  logic            bs_q;
  logic            ready_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [15:0]     data_q;

  logic [7:0]      ch;
  logic            isPrint;
  logic [YW-1:0]   nextY_d;
  logic [AW-1:0]   rowBase, nextRowBase, curAddr, bsAddr;

  always_comb begin
    ch          = 8'(char_data);
    isPrint     = (ch >= 8'h20) && (ch <= 8'h7E);
    nextY_d     = (curY_q == YW'(GRID_ROW - 1)) ? '0 : curY_q + YW'(1);
    rowBase     = AW'(curY_q) * AW'(GRID_COL);
    nextRowBase = AW'(nextY_d) * AW'(GRID_COL);
    curAddr     = rowBase + AW'(curX_q);
    bsAddr      = curAddr - AW'(1);
  end

  // Every transition into a clear state emits its first cell on the same edge,
  // so the counter always holds the index of the next cell still to be written.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_q <= CLEAR_ALL;
      cnt_q   <= '0;
      curX_q  <= '0;
      curY_q  <= '0;
      fg_q    <= DEF_FG;
      bg_q    <= DEF_BG;
      bs_q    <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (attr_we) {bg_q, fg_q} <= attr_data;
      we_q <= 1'b0;
      case (state_q)
        CLEAR_ALL: begin
          if (cnt_q == CW'(CELLS)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            we_q   <= 1'b1;
            addr_q <= AW'(cnt_q);
            data_q <= {bg_q, fg_q, BLANK};
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        IDLE: begin
          if (char_valid && ready_q) begin
            if (isPrint) begin
              we_q    <= 1'b1;
              addr_q  <= curAddr;
              data_q  <= {bg_q, fg_q, ch};
              bs_q    <= 1'b0;
              state_q <= WRITE;
              ready_q <= 1'b0;
            end else if (ch == 8'h08) begin
              if (curX_q != '0) begin
                we_q    <= 1'b1;
                addr_q  <= bsAddr;
                data_q  <= {bg_q, fg_q, BLANK};
                bs_q    <= 1'b1;
                state_q <= WRITE;
                ready_q <= 1'b0;
              end
            end else if (ch == 8'h0A) begin
              curX_q  <= '0;
              curY_q  <= nextY_d;
              we_q    <= 1'b1;
              addr_q  <= nextRowBase;
              data_q  <= {bg_q, fg_q, BLANK};
              cnt_q   <= CW'(1);
              state_q <= CLEAR_ROW;
              ready_q <= 1'b0;
            end else if (ch == 8'h0D) begin
              curX_q <= '0;
            end else if (ch == 8'h0C) begin
              curX_q  <= '0;
              curY_q  <= '0;
              we_q    <= 1'b1;
              addr_q  <= '0;
              data_q  <= {bg_q, fg_q, BLANK};
              cnt_q   <= CW'(1);
              state_q <= CLEAR_ALL;
              ready_q <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (bs_q) begin
            curX_q  <= curX_q - XW'(1);
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else if (curX_q == XW'(GRID_COL - 1)) begin
            curX_q  <= '0;
            curY_q  <= nextY_d;
            we_q    <= 1'b1;
            addr_q  <= nextRowBase;
            data_q  <= {bg_q, fg_q, BLANK};
            cnt_q   <= CW'(1);
            state_q <= CLEAR_ROW;
          end else begin
            curX_q  <= curX_q + XW'(1);
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        CLEAR_ROW: begin
          if (cnt_q == CW'(GRID_COL)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            we_q   <= 1'b1;
            addr_q <= rowBase + AW'(cnt_q);
            data_q <= {bg_q, fg_q, BLANK};
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        default: state_q <= CLEAR_ALL;
      endcase
    end
  end

  assign char_ready = ready_q;
  assign cursor_x   = curX_q;
  assign cursor_y   = curY_q;
  assign bufferWe   = we_q;
  assign bufferAddr = 32'(addr_q);
  assign bufferData = {16'h0, data_q};

endmodule
